reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20000, meaning consecutive stable cycles (1 ms at 20 MHz) before the debounced button changes state.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, meaning cycles both resets stay asserted after the last request clears.
REQ-003 SHALL have parameter STAGGER_CYCLES, default 8, meaning cycles between peripheral release and CPU release.
REQ-004 SHALL have port sysClk_i  input  1  single clock, the 20 MHz MMCM output; all logic is on this clock.
REQ-005 SHALL have port RESETn_i  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port extRstn_i  input  1  board reset button, asynchronous, active-low, bouncing.
REQ-007 SHALL have port wdogRst_i  input  1  watchdog reset request, single-cycle pulse, synchronous to sysClk_i.
REQ-008 SHALL have port swRst_i  input  1  software reset request, single-cycle pulse, synchronous to sysClk_i.
REQ-009 SHALL have port periphRstn_o  output  1  peripheral/bus reset, active-low, registered.
REQ-010 SHALL have port cpuRstn_o  output  1  CPU reset, active-low, registered.
REQ-011 SHALL have port rstCause_o  output  3  cause of the last reset: 001 POR, 010 EXT, 011 WDOG, 100 SW.
REQ-012 SHALL have port rstActive_o  output  1  high while cpuRstn_o is low.

Function
REQ-013 SHALL synchronize extRstn_i through a 2-flop synchronizer before any other use.
REQ-014 SHALL flip the debounced button level only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count.
REQ-015 SHALL treat the button request (extReq) as a level, active while the debounced level is low.
REQ-016 SHALL implement the FSM states HOLD, REL_PERIPH and RUN.
REQ-017 In HOLD, both outputs SHALL be low; a 16-bit counter SHALL increment only while no request is active, and the FSM SHALL go to REL_PERIPH when count reaches HOLD_CYCLES-1.
REQ-018 In REL_PERIPH, periphRstn_o SHALL be high and cpuRstn_o low; the FSM SHALL go to RUN after STAGGER_CYCLES cycles.
REQ-019 In RUN, both outputs SHALL be high.
REQ-020 In any state, extReq, wdogRst_i or swRst_i SHALL force HOLD and clear the counter; both outputs SHALL be low on the next edge (1-cycle latency).
REQ-021 Timing: periphRstn_o SHALL rise exactly HOLD_CYCLES edges after the first edge with no request active, and cpuRstn_o SHALL rise exactly STAGGER_CYCLES edges after that.
REQ-022 Simultaneous requests: rstCause_o SHALL take priority EXT > WDOG > SW; it updates only on a request edge and holds through the sequence.
REQ-023 A request arriving during HOLD or REL_PERIPH SHALL restart HOLD and overwrite rstCause_o.
REQ-024 HOLD_CYCLES and STAGGER_CYCLES SHALL be >= 1; values >= 65536 are illegal (elaboration assertion).

Reset
REQ-025 With RESETn_i sampled low, the block SHALL set state HOLD, counter 0, periphRstn_o=0, cpuRstn_o=0, rstActive_o=1, rstCause_o=001, debounced level=1, debounce counter 0 and synchronizer flops=1.
REQ-026 RESETn_i asserted mid-sequence SHALL abort the sequence and reapply the values in REQ-025 on that edge.

Structure
REQ-027 Package reset_seq_pkg SHALL hold the state enum, the cause enum/encodings and the default parameter constants.
REQ-028 The synchronizer and debounce logic (REQ-013/014) SHALL be one sub-module, reset_debounce; the FSM and counters SHALL stay in reset_sequencer.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, STAGGER_CYCLES=8)
REQ-029 POR: RESETn_i low for 5 cycles, then high -> periphRstn_o rises 16 edges later, cpuRstn_o 8 edges after that, rstCause_o=001.
REQ-030 Button: extRstn_i low for 3 cycles -> ignored; low for 10 cycles -> both resets low, cause=010; release -> periph rises 4+2 sync+16 edges after the release is seen.
REQ-031 Watchdog: one-cycle wdogRst_i in RUN -> both resets low on the next edge, cause=011, full 16/8 release sequence follows.
REQ-032 Collision: wdogRst_i and swRst_i in the same cycle -> cause=011; swRst_i 5 cycles into REL_PERIPH -> periph low next edge, cause=100, HOLD restarts from 0.
REQ-033 Mid-sequence reset: RESETn_i low during REL_PERIPH -> on that edge all outputs match REQ-025 and cause=001.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the reset sequencer: FSM states, reset-cause codes,
// counter widths and default timing parameters.
package reset_seq_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 20000;
  localparam int unsigned HOLD_CYCLES_DEF     = 16;
  localparam int unsigned STAGGER_CYCLES_DEF  = 8;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned CAUSE_W = 3;
  localparam int unsigned CNT_LIMIT = 65536;

  typedef enum logic [1:0] {
    ST_HOLD       = 2'd0,
    ST_REL_PERIPH = 2'd1,
    ST_RUN        = 2'd2
  } seq_state_e;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_POR  = 3'b001,
    CAUSE_EXT  = 3'b010,
    CAUSE_WDOG = 3'b011,
    CAUSE_SW   = 3'b100
  } rst_cause_e;

endpackage

// File: rtl/reset_debounce.sv
// Two-flop synchronizer plus debouncer for the active-low board reset button.
// The output level changes only after the synchronized input has differed for DEBOUNCE_CYCLES edges.
module reset_debounce
  import reset_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic btn_level_o
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            level_q, level_d;
  logic [DB_W-1:0] cnt_q,   cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any cycle where the synchronized level agrees with the debounced one restarts the count.
  always_comb begin
    sync1_d = btn_n_i;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end
  end

  assign btn_level_o = level_q;

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: merges button, watchdog and software reset requests, holds both resets,
// then releases the peripheral reset followed by the CPU reset, and records the reset cause.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int unsigned STAGGER_CYCLES  = STAGGER_CYCLES_DEF
) (
  input  logic               sysClk_i,
  input  logic               RESETn_i,
  input  logic               extRstn_i,
  input  logic               wdogRst_i,
  input  logic               swRst_i,
  output logic               periphRstn_o,
  output logic               cpuRstn_o,
  output logic [CAUSE_W-1:0] rstCause_o,
  output logic               rstActive_o
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES >= CNT_LIMIT) begin : g_bad_hold
    $error("HOLD_CYCLES must be in 1..65535");
  end
  if (STAGGER_CYCLES < 1 || STAGGER_CYCLES >= CNT_LIMIT) begin : g_bad_stagger
    $error("STAGGER_CYCLES must be in 1..65535");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 1");
  end

  logic             btn_level;
  logic             ext_req_c;
  logic             any_req_c;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  rst_cause_e       cause_q, cause_d;
  logic             periph_q, periph_d;
  logic             cpu_q,    cpu_d;
  logic             active_q, active_d;

  reset_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk         (sysClk_i),
    .rst_n       (RESETn_i),
    .btn_n_i     (extRstn_i),
    .btn_level_o (btn_level)
  );

  assign ext_req_c = ~btn_level;
  assign any_req_c = ext_req_c | wdogRst_i | swRst_i;

  always_ff @(posedge sysClk_i) begin
    if (!RESETn_i) begin
      state_q  <= ST_HOLD;
      cnt_q    <= '0;
      cause_q  <= CAUSE_POR;
      periph_q <= 1'b0;
      cpu_q    <= 1'b0;
      active_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      periph_q <= periph_d;
      cpu_q    <= cpu_d;
      active_q <= active_d;
    end
  end

  // One shared counter times the hold window, then the peripheral-to-CPU stagger.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    if (any_req_c) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      if (ext_req_c)      cause_d = CAUSE_EXT;
      else if (wdogRst_i) cause_d = CAUSE_WDOG;
      else                cause_d = CAUSE_SW;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            state_d = ST_REL_PERIPH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_REL_PERIPH: begin
          if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: cnt_d = '0;
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    periph_d = 1'b0;
    cpu_d    = 1'b0;
    case (state_d)
      ST_REL_PERIPH: periph_d = 1'b1;
      ST_RUN: begin
        periph_d = 1'b1;
        cpu_d    = 1'b1;
      end
      default: ;
    endcase
    active_d = ~cpu_d;
  end

  assign periphRstn_o = periph_q;
  assign cpuRstn_o    = cpu_q;
  assign rstCause_o   = cause_q;
  assign rstActive_o  = active_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed release-timing scenarios followed by random requests,
// every edge compared with a model built on "edges since the last request".
module tb_reset_sequencer;

  localparam int unsigned DB   = 4;
  localparam int unsigned HOLD = 16;
  localparam int unsigned STAG = 8;

  logic       clk = 1'b0;
  logic       RESETn_i = 1'b0;
  logic       extRstn_i = 1'b1;
  logic       wdogRst_i = 1'b0;
  logic       swRst_i = 1'b0;
  logic       periphRstn_o;
  logic       cpuRstn_o;
  logic [2:0] rstCause_o;
  logic       rstActive_o;

  int n_total = 0;
  int n_bad   = 0;

  // model state
  logic       m_s1 = 1'b1;
  logic       m_s2 = 1'b1;
  logic       m_deb = 1'b1;
  int         m_dcnt = 0;
  int         m_quiet = 0;
  logic [2:0] m_cause = 3'b001;

  reset_sequencer #(
    .DEBOUNCE_CYCLES (DB),
    .HOLD_CYCLES     (HOLD),
    .STAGGER_CYCLES  (STAG)
  ) dut (
    .sysClk_i     (clk),
    .RESETn_i     (RESETn_i),
    .extRstn_i    (extRstn_i),
    .wdogRst_i    (wdogRst_i),
    .swRst_i      (swRst_i),
    .periphRstn_o (periphRstn_o),
    .cpuRstn_o    (cpuRstn_o),
    .rstCause_o   (rstCause_o),
    .rstActive_o  (rstActive_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Resets are released once HOLD edges have passed with no request, the CPU STAG edges later.
  task automatic model_edge();
    logic ext_req;
    logic any_req;
    if (!RESETn_i) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_deb = 1'b1; m_dcnt = 0;
      m_quiet = 0; m_cause = 3'b001;
    end else begin
      ext_req = !m_deb;
      any_req = ext_req || wdogRst_i || swRst_i;
      if (any_req) begin
        m_quiet = 0;
        m_cause = ext_req ? 3'b010 : (wdogRst_i ? 3'b011 : 3'b100);
      end else if (m_quiet < 1000) begin
        m_quiet++;
      end
      if (m_s2 != m_deb) begin
        m_dcnt++;
        if (m_dcnt == int'(DB)) begin
          m_deb  = m_s2;
          m_dcnt = 0;
        end
      end else begin
        m_dcnt = 0;
      end
      m_s2 = m_s1;
      m_s1 = extRstn_i;
    end
  endtask

  task automatic step(input logic ext, input logic wd, input logic sw, input logic rn);
    logic exp_p;
    logic exp_c;
    @(negedge clk);
    extRstn_i = ext;
    wdogRst_i = wd;
    swRst_i   = sw;
    RESETn_i  = rn;
    @(posedge clk);
    model_edge();
    #1;
    exp_p = (m_quiet >= int'(HOLD));
    exp_c = (m_quiet >= int'(HOLD + STAG));
    chk("periph", 32'(periphRstn_o), 32'(exp_p));
    chk("cpu",    32'(cpuRstn_o),    32'(exp_c));
    chk("active", 32'(rstActive_o),  32'(!exp_c));
    chk("cause",  32'(rstCause_o),   32'(m_cause));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic ext_lvl;

    // power-on reset
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_periph", 32'(periphRstn_o), 32'd0);
    chk("rst_cpu",    32'(cpuRstn_o),    32'd0);
    chk("rst_active", 32'(rstActive_o),  32'd1);
    chk("rst_cause",  32'(rstCause_o),   32'd1);
    idle(15); chk("por_periph_pre",  32'(periphRstn_o), 32'd0);
    idle(1);  chk("por_periph_rise", 32'(periphRstn_o), 32'd1);
    chk("por_cpu_lo", 32'(cpuRstn_o), 32'd0);
    idle(7);  chk("por_cpu_pre",  32'(cpuRstn_o), 32'd0);
    idle(1);  chk("por_cpu_rise", 32'(cpuRstn_o), 32'd1);
    chk("por_active_lo", 32'(rstActive_o), 32'd0);
    chk("por_cause",     32'(rstCause_o),  32'd1);

    // short glitch on the button is ignored
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(10);
    chk("short_periph", 32'(periphRstn_o), 32'd1);
    chk("short_cpu",    32'(cpuRstn_o),    32'd1);
    chk("short_cause",  32'(rstCause_o),   32'd1);

    // long press resets; release timing = debounce + sync + hold
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ext_periph", 32'(periphRstn_o), 32'd0);
    chk("ext_cpu",    32'(cpuRstn_o),    32'd0);
    chk("ext_cause",  32'(rstCause_o),   32'd2);
    idle(21); chk("ext_rel_pre",  32'(periphRstn_o), 32'd0);
    idle(1);  chk("ext_rel_rise", 32'(periphRstn_o), 32'd1);
    idle(8);  chk("ext_cpu_rise", 32'(cpuRstn_o),    32'd1);

    // watchdog pulse in RUN
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("wd_periph", 32'(periphRstn_o), 32'd0);
    chk("wd_cpu",    32'(cpuRstn_o),    32'd0);
    chk("wd_cause",  32'(rstCause_o),   32'd3);
    idle(15); chk("wd_periph_pre",  32'(periphRstn_o), 32'd0);
    idle(1);  chk("wd_periph_rise", 32'(periphRstn_o), 32'd1);
    idle(7);  chk("wd_cpu_pre",     32'(cpuRstn_o),    32'd0);
    idle(1);  chk("wd_cpu_rise",    32'(cpuRstn_o),    32'd1);

    // simultaneous watchdog + software, then software during REL_PERIPH
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("coll_cause", 32'(rstCause_o), 32'd3);
    idle(16); chk("coll_rel", 32'(periphRstn_o), 32'd1);
    idle(5);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("sw_periph", 32'(periphRstn_o), 32'd0);
    chk("sw_cause",  32'(rstCause_o),   32'd4);
    idle(15); chk("sw_periph_pre",  32'(periphRstn_o), 32'd0);
    idle(1);  chk("sw_periph_rise", 32'(periphRstn_o), 32'd1);

    // system reset while releasing
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("mid_periph", 32'(periphRstn_o), 32'd0);
    chk("mid_cpu",    32'(cpuRstn_o),    32'd0);
    chk("mid_active", 32'(rstActive_o),  32'd1);
    chk("mid_cause",  32'(rstCause_o),   32'd1);

    // random traffic
    ext_lvl = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) ext_lvl = !ext_lvl;
      step(ext_lvl,
           ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 399) != 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
